// File: rtl/dac_scan_pkg.sv
// Shared definitions for the DAC scan sequencer: FSM states, register map,
// CTRL bit positions and small sizing constants.
package dac_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_DAC,
    SETTLE,
    COUNT,
    NEXT,
    DONE
  } state_t;

  localparam logic [7:0] ADDR_CTRL      = 8'h40;
  localparam logic [7:0] ADDR_START_LO  = 8'h41;
  localparam logic [7:0] ADDR_START_HI  = 8'h42;
  localparam logic [7:0] ADDR_STOP_LO   = 8'h43;
  localparam logic [7:0] ADDR_STOP_HI   = 8'h44;
  localparam logic [7:0] ADDR_STEP      = 8'h45;
  localparam logic [7:0] ADDR_SETTLE_LO = 8'h46;
  localparam logic [7:0] ADDR_SETTLE_HI = 8'h47;
  localparam logic [7:0] ADDR_CUR_LO    = 8'h48;
  localparam logic [7:0] ADDR_CUR_HI    = 8'h49;
  localparam logic [7:0] ADDR_POINT     = 8'h4A;

  // CTRL write bits
  localparam int CTRL_GO    = 0;
  localparam int CTRL_ABORT = 1;

  localparam int POINT_W = 8;

  // Cycles tolerated in WAIT_DAC without seeing dac_ready drop (value + 1).
  localparam logic [1:0] WAIT_DAC_MAX = 2'd3;

endpackage

// File: rtl/dac_scan_regs.sv
// Register file for the scan sequencer.
// Ports: clk/init (sync reset), we/addr/data_in (write side), data_out
// (registered read, 1-cycle latency), busy/done_sticky/cur/point (status
// to read back), start/stop/step/settle (scan configuration), go/abort
// (decoded CTRL strobes, combinational from the write cycle).
// Configuration is frozen while a scan is running; CTRL is always writable.
module dac_scan_regs
  import dac_scan_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CODE_WIDTH   = 12,
  parameter int SETTLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    init,
  input  logic                    we,
  input  logic [DATA_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    busy,
  input  logic                    done_sticky,
  input  logic [CODE_WIDTH-1:0]   cur,
  input  logic [POINT_W-1:0]      point,
  output logic [CODE_WIDTH-1:0]   start,
  output logic [CODE_WIDTH-1:0]   stop,
  output logic [DATA_WIDTH-1:0]   step,
  output logic [SETTLE_WIDTH-1:0] settle,
  output logic                    go,
  output logic                    abort,
  output logic [DATA_WIDTH-1:0]   data_out
);

  logic ctrl_wr;

  // ABORT dominates: a combined GO|ABORT write never starts a scan.
  assign ctrl_wr = we && (addr == ADDR_CTRL);
  assign abort   = ctrl_wr && data_in[CTRL_ABORT];
  assign go      = ctrl_wr && data_in[CTRL_GO] && !data_in[CTRL_ABORT];

  always_ff @(posedge clk) begin
    if (init) begin
      start    <= '0;
      stop     <= '0;
      step     <= '0;
      settle   <= '0;
      data_out <= '0;
    end else begin
      if (we && !busy) begin
        case (addr)
          ADDR_START_LO:  start[DATA_WIDTH-1:0]            <= data_in;
          ADDR_START_HI:  start[CODE_WIDTH-1:DATA_WIDTH]   <= data_in[CODE_WIDTH-DATA_WIDTH-1:0];
          ADDR_STOP_LO:   stop[DATA_WIDTH-1:0]             <= data_in;
          ADDR_STOP_HI:   stop[CODE_WIDTH-1:DATA_WIDTH]    <= data_in[CODE_WIDTH-DATA_WIDTH-1:0];
          ADDR_STEP:      step                             <= data_in;
          ADDR_SETTLE_LO: settle[DATA_WIDTH-1:0]           <= data_in;
          ADDR_SETTLE_HI: settle[SETTLE_WIDTH-1:DATA_WIDTH] <= data_in[SETTLE_WIDTH-DATA_WIDTH-1:0];
          default: ;
        endcase
      end
      // Unmapped addresses leave data_out unchanged.
      case (addr)
        ADDR_CTRL:      data_out <= DATA_WIDTH'({busy, done_sticky});
        ADDR_START_LO:  data_out <= start[DATA_WIDTH-1:0];
        ADDR_START_HI:  data_out <= DATA_WIDTH'(start[CODE_WIDTH-1:DATA_WIDTH]);
        ADDR_STOP_LO:   data_out <= stop[DATA_WIDTH-1:0];
        ADDR_STOP_HI:   data_out <= DATA_WIDTH'(stop[CODE_WIDTH-1:DATA_WIDTH]);
        ADDR_STEP:      data_out <= step;
        ADDR_SETTLE_LO: data_out <= settle[DATA_WIDTH-1:0];
        ADDR_SETTLE_HI: data_out <= DATA_WIDTH'(settle[SETTLE_WIDTH-1:DATA_WIDTH]);
        ADDR_CUR_LO:    data_out <= cur[DATA_WIDTH-1:0];
        ADDR_CUR_HI:    data_out <= DATA_WIDTH'(cur[CODE_WIDTH-1:DATA_WIDTH]);
        ADDR_POINT:     data_out <= DATA_WIDTH'(point);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dac_scan_sequencer.sv
// Steps the DAC code from START to STOP by STEP; per point: load the DAC,
// wait for the writer to finish, settle, then open one counting window.
// Ports: clk, init (sync reset), we/addr/data_in/data_out (register bus),
// dac_code/dac_load/dac_ready (DAC writer handshake), win_start/win_done
// (counter window handshake), busy (scan active), scan_done (end pulse).
module dac_scan_sequencer
  import dac_scan_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CODE_WIDTH   = 12,
  parameter int SETTLE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  init,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CODE_WIDTH-1:0] dac_code,
  output logic                  dac_load,
  input  logic                  dac_ready,
  output logic                  win_start,
  input  logic                  win_done,
  output logic                  busy,
  output logic                  scan_done
);

  state_t                  state_q, state_d;
  logic [CODE_WIDTH-1:0]   cur_q, cur_d;
  logic [CODE_WIDTH-1:0]   code_d;
  logic [POINT_W-1:0]      point_q, point_d;
  logic [SETTLE_WIDTH-1:0] settle_cnt_q, settle_cnt_d;
  logic [1:0]              wait_cnt_q, wait_cnt_d;
  logic                    seen_low_q, seen_low_d;
  logic                    done_sticky_q, done_sticky_d;
  logic                    load_d, win_d;

  logic [CODE_WIDTH-1:0]   start, stop, step_ext;
  logic [DATA_WIDTH-1:0]   step;
  logic [SETTLE_WIDTH-1:0] settle;
  logic                    go, abort;
  logic [CODE_WIDTH:0]     sum;

  function automatic logic [POINT_W-1:0] sat_inc(input logic [POINT_W-1:0] v);
    return (v == '1) ? v : v + POINT_W'(1);
  endfunction

  dac_scan_regs #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CODE_WIDTH  (CODE_WIDTH),
    .SETTLE_WIDTH(SETTLE_WIDTH)
  ) u_regs (
    .clk        (clk),
    .init       (init),
    .we         (we),
    .addr       (addr),
    .data_in    (data_in),
    .busy       (busy),
    .done_sticky(done_sticky_q),
    .cur        (cur_q),
    .point      (point_q),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .settle     (settle),
    .go         (go),
    .abort      (abort),
    .data_out   (data_out)
  );

  assign busy      = (state_q != IDLE);
  assign scan_done = (state_q == DONE);

  // One extra bit so a step past the top code ends the scan instead of wrapping.
  assign step_ext = (step == '0) ? CODE_WIDTH'(1) : CODE_WIDTH'(step);
  assign sum      = {1'b0, cur_q} + {1'b0, step_ext};

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    code_d        = dac_code;
    point_d       = point_q;
    settle_cnt_d  = settle_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    seen_low_d    = seen_low_q;
    done_sticky_d = done_sticky_q;
    load_d        = 1'b0;
    win_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          cur_d         = start;
          point_d       = '0;
          done_sticky_d = 1'b0;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        if (dac_ready) begin
          load_d     = 1'b1;
          code_d     = cur_q;
          wait_cnt_d = '0;
          seen_low_d = 1'b0;
          state_d    = WAIT_DAC;
        end
      end
      WAIT_DAC: begin
        // A writer that never drops ready is assumed finished after a few cycles.
        if (!dac_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q || wait_cnt_q == WAIT_DAC_MAX) begin
          settle_cnt_d = settle;
          state_d      = SETTLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == '0) begin
          win_d   = 1'b1;
          state_d = COUNT;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_WIDTH'(1);
        end
      end
      COUNT: begin
        if (win_done) state_d = NEXT;
      end
      NEXT: begin
        if (cur_q == stop || sum > {1'b0, stop}) begin
          state_d = DONE;
        end else begin
          cur_d   = sum[CODE_WIDTH-1:0];
          point_d = sat_inc(point_q);
          state_d = LOAD;
        end
      end
      DONE: begin
        done_sticky_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over whatever the current state wanted to do.
    if (abort && state_q != IDLE && state_q != DONE) begin
      state_d = DONE;
      load_d  = 1'b0;
      win_d   = 1'b0;
      code_d  = dac_code;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      dac_code      <= '0;
      point_q       <= '0;
      settle_cnt_q  <= '0;
      wait_cnt_q    <= '0;
      seen_low_q    <= 1'b0;
      done_sticky_q <= 1'b0;
      dac_load      <= 1'b0;
      win_start     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      dac_code      <= code_d;
      point_q       <= point_d;
      settle_cnt_q  <= settle_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      seen_low_q    <= seen_low_d;
      done_sticky_q <= done_sticky_d;
      dac_load      <= load_d;
      win_start     <= win_d;
    end
  end

endmodule

// File: tb/tb_dac_scan_sequencer.sv
module tb_dac_scan_sequencer;

  logic        clk = 1'b0;
  logic        init = 1'b1;
  logic        we = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic [11:0] dac_code;
  logic        dac_load;
  logic        dac_ready;
  logic        win_start;
  logic        win_done;
  logic        busy;
  logic        scan_done;

  int n_chk = 0;
  int n_err = 0;

  // bench-side DAC writer / counter models
  int   low_cnt = 0;
  logic force_low = 1'b0;
  int   wcnt = 0;
  logic win_en = 1'b1;
  logic model_wd = 1'b0;
  logic man_wd = 1'b0;

  // event monitor
  int          n_load = 0;
  int          n_win = 0;
  int          n_done = 0;
  logic [11:0] cap [16];

  typedef struct {
    logic [11:0]       start;
    logic [11:0]       stop;
    logic [7:0]        step;
    logic [15:0]       settle;
    int                npts;
    logic [3:0][11:0]  codes;
  } vec_t;

  vec_t vecs [6];

  assign dac_ready = !force_low && (low_cnt == 0);
  assign win_done  = model_wd | man_wd;

  dac_scan_sequencer dut (
    .clk      (clk),
    .init     (init),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .dac_code (dac_code),
    .dac_load (dac_load),
    .dac_ready(dac_ready),
    .win_start(win_start),
    .win_done (win_done),
    .busy     (busy),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dac_load) low_cnt = 3;
    else if (low_cnt > 0) low_cnt = low_cnt - 1;
    model_wd = 1'b0;
    if (win_start) wcnt = 5;
    else if (wcnt > 0) begin
      wcnt = wcnt - 1;
      if (wcnt == 0 && win_en) model_wd = 1'b1;
    end
    if (dac_load) begin
      if (n_load < 16) cap[n_load] = dac_code;
      n_load = n_load + 1;
    end
    if (win_start) n_win = n_win + 1;
    if (scan_done) n_done = n_done + 1;
  end

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; data_in = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    addr = a; we = 1'b0;
    @(negedge clk);
    v = data_out;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("scan_finishes", busy, 0);
  endtask

  task automatic clear_log();
    n_load = 0; n_win = 0; n_done = 0;
  endtask

  task automatic config_scan(input logic [11:0] s, input logic [11:0] e,
                             input logic [7:0] st, input logic [15:0] se);
    wr(8'h41, s[7:0]);  wr(8'h42, {4'h0, s[11:8]});
    wr(8'h43, e[7:0]);  wr(8'h44, {4'h0, e[11:8]});
    wr(8'h45, st);
    wr(8'h46, se[7:0]); wr(8'h47, se[15:8]);
  endtask

  initial begin
    logic [7:0] v;
    int k;

    vecs[0] = '{12'h100, 12'h104, 8'd2,    16'd3, 3, {12'h000, 12'h104, 12'h102, 12'h100}};
    vecs[1] = '{12'hFF0, 12'hFFF, 8'h20,   16'd1, 1, {12'h000, 12'h000, 12'h000, 12'hFF0}};
    vecs[2] = '{12'h200, 12'h100, 8'd1,    16'd0, 1, {12'h000, 12'h000, 12'h000, 12'h200}};
    vecs[3] = '{12'h010, 12'h012, 8'd0,    16'd2, 3, {12'h000, 12'h012, 12'h011, 12'h010}};
    vecs[4] = '{12'hFFE, 12'hFFF, 8'd1,    16'd0, 2, {12'h000, 12'h000, 12'hFFF, 12'hFFE}};
    vecs[5] = '{12'h000, 12'h009, 8'd4,    16'd1, 3, {12'h000, 12'h008, 12'h004, 12'h000}};

    repeat (3) @(negedge clk);
    init = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_busy", busy, 0);
    check("rst_dac_load", dac_load, 0);
    check("rst_win_start", win_start, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_dac_code", dac_code, 0);
    rd(8'h40, v); check("rst_ctrl", v, 8'h00);
    rd(8'h43, v); check("rst_stop_lo", v, 8'h00);

    // table-driven scans
    for (int i = 0; i < 6; i++) begin
      config_scan(vecs[i].start, vecs[i].stop, vecs[i].step, vecs[i].settle);
      clear_log();
      wr(8'h40, 8'h01);
      wait_idle(400);
      check($sformatf("v%0d_loads", i), n_load, vecs[i].npts);
      check($sformatf("v%0d_windows", i), n_win, vecs[i].npts);
      check($sformatf("v%0d_done", i), n_done, 1);
      for (int j = 0; j < vecs[i].npts; j++)
        check($sformatf("v%0d_code%0d", i, j), cap[j], vecs[i].codes[j]);
      rd(8'h40, v); check($sformatf("v%0d_ctrl", i), v, 8'h01);
      rd(8'h4A, v); check($sformatf("v%0d_point", i), v, vecs[i].npts - 1);
      rd(8'h48, v); check($sformatf("v%0d_cur_lo", i), v, vecs[i].codes[vecs[i].npts-1][7:0]);
      rd(8'h49, v); check($sformatf("v%0d_cur_hi", i), v, {4'h0, vecs[i].codes[vecs[i].npts-1][11:8]});
    end

    // GO -> first dac_load latency of 2 cycles
    config_scan(12'h300, 12'h300, 8'd1, 16'd0);
    clear_log();
    wr(8'h40, 8'h01);
    check("lat_load_early", dac_load, 0);
    @(negedge clk);
    check("lat_load", dac_load, 1);
    check("lat_code", dac_code, 12'h300);
    wait_idle(200);

    // GO and ABORT in one write: nothing starts
    clear_log();
    wr(8'h40, 8'h03);
    repeat (3) @(negedge clk);
    check("goabort_busy", busy, 0);
    check("goabort_loads", n_load, 0);

    // ABORT during SETTLE of point 2
    config_scan(12'h100, 12'h104, 8'd2, 16'd20);
    clear_log();
    wr(8'h40, 8'h01);
    k = 0;
    while (n_load < 2 && k < 200) begin @(negedge clk); k++; end
    check("abort_reach_pt2", n_load, 2);
    repeat (8) @(negedge clk);
    wr(8'h40, 8'h02);
    check("abort_scan_done", scan_done, 1);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_scan_done_pulse", scan_done, 0);
    repeat (30) @(negedge clk);
    check("abort_windows", n_win, 1);
    check("abort_loads", n_load, 2);
    check("abort_done_cnt", n_done, 1);
    check("abort_code_held", dac_code, 12'h102);
    rd(8'h40, v); check("abort_ctrl", v, 8'h01);

    // dac_ready held low before first load; STOP write while busy ignored
    config_scan(12'h310, 12'h310, 8'd1, 16'd0);
    clear_log();
    force_low = 1'b1;
    wr(8'h40, 8'h01);
    repeat (20) @(negedge clk);
    check("rdylow_loads", n_load, 0);
    check("rdylow_busy", busy, 1);
    wr(8'h43, 8'h55);
    rd(8'h43, v); check("frozen_stop_lo", v, 8'h10);
    rd(8'h40, v); check("busy_ctrl", v, 8'h02);
    force_low = 1'b0;
    wait_idle(200);
    check("rdylow_loads_after", n_load, 1);
    check("rdylow_code", cap[0], 12'h310);

    // init asserted during COUNT
    config_scan(12'h123, 12'h200, 8'd1, 16'd0);
    clear_log();
    win_en = 1'b0;
    wr(8'h40, 8'h01);
    k = 0;
    while (n_win < 1 && k < 200) begin @(negedge clk); k++; end
    check("init_reach_count", n_win, 1);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("init_busy", busy, 0);
    check("init_dac_code", dac_code, 0);
    check("init_dac_load", dac_load, 0);
    check("init_win_start", win_start, 0);
    check("init_scan_done", scan_done, 0);
    check("init_data_out", data_out, 0);
    man_wd = 1'b1;
    @(negedge clk);
    man_wd = 1'b0;
    repeat (5) @(negedge clk);
    check("init_wd_ignored_busy", busy, 0);
    check("init_wd_ignored_loads", n_load, 1);
    rd(8'h41, v); check("init_start_lo", v, 8'h00);
    rd(8'h40, v); check("init_ctrl", v, 8'h00);
    win_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
